// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller:
// opcodes, FSM state codes, mux selects and the control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath/memory bundle; the controller
// is the master, the datapath side is the slave.
interface mips_multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                zero;
    logic                pc_write;
    logic                pc_write_cond;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          reg_dst;
    logic [1:0]          mem_to_reg;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_src;
    logic [3:0]          state_o;
    logic                illegal_op;
    logic [CNT_W-1:0]    instr_retired;

    modport master (
        input  opcode, mem_ready, zero,
        output pc_write, pc_write_cond, iord, mem_read,
        output mem_write, ir_write, reg_write, alu_src_a,
        output reg_dst, mem_to_reg, alu_src_b, alu_op,
        output pc_src, state_o, illegal_op, instr_retired
    );

    modport slave (
        output opcode, mem_ready, zero,
        input  pc_write, pc_write_cond, iord, mem_read,
        input  mem_write, ir_write, reg_write, alu_src_a,
        input  reg_dst, mem_to_reg, alu_src_b, alu_op,
        input  pc_src, state_o, illegal_op, instr_retired
    );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// State -> raw control word; memory-handshake gating
// and reset masking are applied by the top.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = M2R_MDR;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = RDST_RD;
                ctrl.reg_write = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            S_JAL: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.reg_dst    = RDST_RA;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.reg_write  = 1'b1;
            end
            S_TRAP:  ctrl.illegal_op = 1'b1;
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with memory wait states,
// illegal-opcode trap and retired-instruction counter.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 6,
    parameter int ENABLE_JAL = 1,
    parameter int CNT_W      = 32
) (
    input logic clk,
    input logic reset,
    mips_multicycle_control_if.master bus
);
    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic             retire;
    ctrl_t            dcw;
    ctrl_t            cw;

    function automatic state_t dec_op(input logic [OPCODE_W-1:0] op);
        state_t s;
        s = S_TRAP;
        if (op == OPCODE_W'(OP_RTYPE))                       s = S_REXEC;
        else if (op == OPCODE_W'(OP_LW))                     s = S_MEMADR;
        else if (op == OPCODE_W'(OP_SW))                     s = S_MEMADR;
        else if (op == OPCODE_W'(OP_BEQ))                    s = S_BEQ;
        else if (op == OPCODE_W'(OP_ADDI))                   s = S_ADDIEX;
        else if (op == OPCODE_W'(OP_J))                      s = S_JUMP;
        else if (op == OPCODE_W'(OP_JAL) && ENABLE_JAL != 0) s = S_JAL;
        return s;
    endfunction

    always_comb begin
        nxt = S_FETCH;
        case (state)
            S_FETCH:  nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: nxt = dec_op(bus.opcode);
            S_MEMADR: nxt = (bus.opcode == OPCODE_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_REXEC:  nxt = S_ALUWB;
            S_ADDIEX: nxt = S_ADDIWB;
            default:  nxt = S_FETCH;
        endcase
    end

    // Trap returns to FETCH without counting as a retirement
    always_comb begin
        retire = 1'b0;
        case (state)
            S_MEMWB, S_ALUWB, S_BEQ,
            S_ADDIWB, S_JUMP, S_JAL: retire = 1'b1;
            S_MEMWR:                 retire = bus.mem_ready;
            default:                 retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= nxt;
            if (retire) cnt <= cnt + CNT_W'(1);
        end
    end

    mips_ctrl_outdec u_outdec (
        .state (state),
        .ctrl  (dcw)
    );

    // Reset masks every write strobe, even while state reads FETCH
    always_comb begin
        cw = dcw;
        if (state == S_FETCH) begin
            cw.pc_write = bus.mem_ready;
            cw.ir_write = bus.mem_ready;
        end
        if (reset) begin
            cw.pc_write      = 1'b0;
            cw.pc_write_cond = 1'b0;
            cw.ir_write      = 1'b0;
            cw.reg_write     = 1'b0;
            cw.mem_write     = 1'b0;
        end
    end

    assign bus.pc_write      = cw.pc_write;
    assign bus.pc_write_cond = cw.pc_write_cond;
    assign bus.iord          = cw.iord;
    assign bus.mem_read      = cw.mem_read;
    assign bus.mem_write     = cw.mem_write;
    assign bus.ir_write      = cw.ir_write;
    assign bus.reg_write     = cw.reg_write;
    assign bus.alu_src_a     = cw.alu_src_a;
    assign bus.reg_dst       = cw.reg_dst;
    assign bus.mem_to_reg    = cw.mem_to_reg;
    assign bus.alu_src_b     = cw.alu_src_b;
    assign bus.alu_op        = cw.alu_op;
    assign bus.pc_src        = cw.pc_src;
    assign bus.illegal_op    = cw.illegal_op;
    assign bus.state_o       = state;
    assign bus.instr_retired = cnt;
endmodule
